// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - N-channel arbitrated mux with a single registered output slot
// Fixed-priority or round-robin grant; one word per cycle when downstream keeps up.
module arb_mux_n #(
  parameter int WIDTH = 3,
  parameter int NCH   = 2,
  parameter int MODE  = 0,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_sel
);

  logic [CW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_sel;
  logic             r_out_valid;

  logic [CW-1:0]    w_base;
  logic [CW-1:0]    w_gidx;
  logic [NCH-1:0]   w_grant;
  logic [WIDTH-1:0] w_gdata;
  logic             w_any;
  logic             w_can_load;
  logic             w_load;

  // Circular search from w_base; fixed priority is the same search pinned at 0.
  always_comb begin
    int idx;
    w_grant = '0;
    w_gidx  = '0;
    w_gdata = '0;
    w_any   = 1'b0;
    w_base  = (MODE == 1) ? r_ptr : '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(w_base) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!w_any && in_valid[idx]) begin
        w_any        = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = CW'(idx);
        w_gdata      = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // rst_n gates the handshake so sources see no accept while reset is held.
  assign w_can_load = rst_n && (!r_out_valid || out_ready);
  assign w_load     = w_any && w_can_load;
  assign in_ready   = w_can_load ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gdata;
      r_out_sel   <= w_gidx;
      if (MODE == 1) begin
        r_ptr <= (w_gidx == CW'(NCH - 1)) ? '0 : w_gidx + 1'b1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule
